debounce_sync: RTL and testbench

Conditions a raw, asynchronous push-button or switch level into a clean, single-clock-domain signal. It feeds the `d` input of the `d_ff` storage stage. The block optionally synchronizes the input and rejects glitches shorter than a programmable number of clock cycles. It emits the debounced level plus one-cycle rise and fall pulses for downstream counters and FSMs.

---
 rtl/debounce_sync.sv | 115 +++++++++++
 tb/tb_debounce_sync.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Debounces a raw button level into a clean clk-domain level with one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the qualifier.
module debounce_sync #(
    parameter int CNT_MAX = 4,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_out;
    logic             r_rise;
    logic             r_fall;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_in};
        end
    end

    assign w_s = r_sync[1];
`else
    assign w_s = btn_in;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_btn_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    // A reverting sample wins over a count that has reached its limit.
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= IDLE_HIGH;
                        r_cnt     <= '0;
                        r_btn_out <= 1'b1;
                        r_rise    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!w_s) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= IDLE_LOW;
                        r_cnt     <= '0;
                        r_btn_out <= 1'b0;
                        r_fall    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_out    = r_btn_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync; latencies follow whether DEBOUNCE_SYNC_EN is defined.
module tb_debounce_sync;

    localparam int CNT_MAX = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int L = CNT_MAX + 1;  // edge index after which an accepted change appears
    localparam int B = 2;            // edge index after which busy first rises
`else
    localparam int L = CNT_MAX - 1;
    localparam int B = 0;
`endif

    logic clk;
    logic reset;
    logic btn_in;
    logic btn_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks   = 0;
    int failures = 0;

    debounce_sync #(.CNT_MAX(CNT_MAX), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_out    (btn_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [3:0] w_obs = {btn_out, rise_pulse, fall_pulse, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        step();
        step();
        checks++;
        if (w_obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_values got=%b want=0000", w_obs);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (w_obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle k=%0d got=%b want=0000", k, w_obs);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp;
        btn_in = 1'b1;
        for (int k = 0; k <= L + 2; k++) begin
            step();
            exp = {k >= L, k == L, 1'b0, (k >= B) && (k < L)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
    endtask

    task automatic test_bounce_high();
        logic [3:0] exp;
        btn_in = 1'b0;
        for (int k = 0; k <= B + 6; k++) begin
            step();
            if (k == 1) btn_in = 1'b1;
            exp = {1'b1, 1'b0, 1'b0, (k >= B) && (k <= B + 1)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL bounce_high k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] exp;
        btn_in = 1'b0;
        for (int k = 0; k <= L + 2; k++) begin
            step();
            exp = {k < L, 1'b0, k == L, (k >= B) && (k < L)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL release k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
    endtask

    task automatic test_glitch_short();
        logic [3:0] exp;
        btn_in = 1'b1;
        for (int k = 0; k <= B + 6; k++) begin
            step();
            if (k == 2) btn_in = 1'b0;
            exp = {1'b0, 1'b0, 1'b0, (k >= B) && (k <= B + 2)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL glitch_3 k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
    endtask

    task automatic test_glitch_accept();
        logic [3:0] exp;
        btn_in = 1'b1;
        for (int k = 0; k <= L; k++) begin
            step();
            if (k == 3) btn_in = 1'b0;
            exp = {k >= L, k == L, 1'b0, (k >= B) && (k < L)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL glitch_4 k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
        for (int k = 0; k < 12; k++) step();
        checks++;
        if (w_obs !== 4'b0000) begin
            failures++;
            $display("FAIL glitch_4_settle got=%b want=0000", w_obs);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        btn_in = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            step();
            exp = {1'b0, 1'b0, 1'b0, k >= B};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_pre k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
        reset = 1'b1;
        step();
        checks++;
        if (w_obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_clear got=%b want=0000", w_obs);
        end
        reset = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            step();
            exp = {k >= L, k == L, 1'b0, (k >= B) && (k < L)};
            checks++;
            if (w_obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_requal k=%0d got=%b want=%b", k, w_obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_high();
        test_release();
        test_glitch_short();
        test_glitch_accept();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
